// File: rtl/flash_boot_pkg.sv
// flash_boot_pkg: shared state type, SPI constants and byte helpers
// for the SPI flash boot loader.
package flash_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_CS_HOLD,
        ST_DONE
    } boot_state_e;

    localparam logic [7:0] SPI_CMD_READ = 8'h03;
    localparam int CMD_BITS  = 8;
    localparam int ADDR_BITS = 24;
    localparam int WORD_BITS = 32;

    // Flash bytes arrive byte0 first; byte0 belongs in the low lane.
    function automatic logic [31:0] le_word(input logic [31:0] msb_first);
        return {msb_first[7:0], msb_first[15:8],
                msb_first[23:16], msb_first[31:24]};
    endfunction

endpackage

// File: rtl/flash_boot_loader_sclk_gen.sv
// spi_sclk_gen: SPI mode-0 clock divider, idles low while disabled,
// with one-cycle strobes on the clk edge that raises or lowers sclk.
module spi_sclk_gen #(
    parameter int SCLK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic sclk,
    output logic rise_tick,
    output logic fall_tick
);
    localparam int CW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          hit;

    assign hit       = en && (cnt == CW'(SCLK_DIV - 1));
    assign rise_tick = hit && !sclk;
    assign fall_tick = hit && sclk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (hit) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/flash_boot_loader.sv
// flash_boot_loader: copies the boot image from SPI flash (READ 0x03) into IMEM.
// Define FLASH_BOOT_CHECKSUM_EN to verify a trailing sum word (adds boot_err).
module flash_boot_loader
    import flash_boot_pkg::*;
#(
    parameter int          IMEM_DEPTH      = 128,
    parameter logic [23:0] FLASH_BASE_ADDR = 24'h300000,
    parameter int          SCLK_DIV        = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    output logic                          o_flash_sclk,
    output logic                          o_flash_cs_n,
    output logic                          o_flash_mosi,
    input  logic                          i_flash_miso,
    output logic                          imem_we,
    output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
    output logic [31:0]                   imem_wdata,
    output logic                          core_rst_n,
    output logic                          boot_done
`ifdef FLASH_BOOT_CHECKSUM_EN
    ,
    output logic                          boot_err
`endif
);
    localparam int AW = $clog2(IMEM_DEPTH);
`ifdef FLASH_BOOT_CHECKSUM_EN
    localparam int NWORDS = IMEM_DEPTH + 1;
`else
    localparam int NWORDS = IMEM_DEPTH;
`endif
    localparam int          WCW      = $clog2(NWORDS);
    localparam logic [15:0] DIV_LAST = 16'(SCLK_DIV - 1);

    boot_state_e                   state;
    logic [15:0]                   cnt;
    logic [CMD_BITS+ADDR_BITS-1:0] tx_sr;
    logic [WORD_BITS-2:0]          rx_sr;
    logic [WORD_BITS-1:0]          word;
    logic [4:0]                    bit_cnt;
    logic [WCW-1:0]                word_cnt;
    logic                          last;
    logic                          is_trailer;
    logic                          sclk_en;
    logic                          rise_tick;
    logic                          fall_tick;
`ifdef FLASH_BOOT_CHECKSUM_EN
    logic [31:0]                   sum;
`endif

    assign sclk_en = (state == ST_CMD) || (state == ST_ADDR) ||
                     (state == ST_DATA);
    assign word    = le_word({rx_sr, i_flash_miso});

`ifdef FLASH_BOOT_CHECKSUM_EN
    assign is_trailer = (word_cnt == WCW'(IMEM_DEPTH));
`else
    assign is_trailer = 1'b0;
`endif

    spi_sclk_gen #(
        .SCLK_DIV(SCLK_DIV)
    ) u_sclk (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (sclk_en),
        .sclk     (o_flash_sclk),
        .rise_tick(rise_tick),
        .fall_tick(fall_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            tx_sr        <= {SPI_CMD_READ, FLASH_BASE_ADDR};
            rx_sr        <= '0;
            bit_cnt      <= '0;
            word_cnt     <= '0;
            last         <= 1'b0;
            o_flash_cs_n <= 1'b1;
            o_flash_mosi <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            core_rst_n   <= 1'b0;
            boot_done    <= 1'b0;
`ifdef FLASH_BOOT_CHECKSUM_EN
            sum          <= '0;
            boot_err     <= 1'b0;
`endif
        end else begin
            imem_we <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    state        <= ST_CS_SETUP;
                    o_flash_cs_n <= 1'b0;
                    o_flash_mosi <= tx_sr[31];
                    tx_sr        <= {tx_sr[30:0], 1'b0};
                    cnt          <= '0;
                end
                ST_CS_SETUP: begin
                    if (cnt == DIV_LAST) begin
                        state <= ST_CMD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_CMD, ST_ADDR: begin
                    if (fall_tick) begin
                        o_flash_mosi <= tx_sr[31];
                        tx_sr        <= {tx_sr[30:0], 1'b0};
                        cnt          <= cnt + 1'b1;
                        if (state == ST_CMD && cnt == 16'(CMD_BITS - 1)) begin
                            state <= ST_ADDR;
                            cnt   <= '0;
                        end
                        if (state == ST_ADDR && cnt == 16'(ADDR_BITS - 1)) begin
                            state <= ST_DATA;
                            cnt   <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (rise_tick) begin
                        rx_sr   <= {rx_sr[WORD_BITS-3:0], i_flash_miso};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 5'(WORD_BITS - 1)) begin
                            if (word_cnt == WCW'(NWORDS - 1))
                                last <= 1'b1;
                            else
                                word_cnt <= word_cnt + 1'b1;
`ifdef FLASH_BOOT_CHECKSUM_EN
                            if (is_trailer)
                                boot_err <= (word != sum);
                            else
                                sum <= sum + word;
`endif
                            if (!is_trailer) begin
                                imem_we    <= 1'b1;
                                imem_addr  <= word_cnt[AW-1:0];
                                imem_wdata <= word;
                            end
                        end
                    end
                    // Leave on the fall after the final sample so sclk ends low.
                    if (fall_tick && last) begin
                        state <= ST_CS_HOLD;
                        cnt   <= '0;
                    end
                end
                ST_CS_HOLD: begin
                    if (cnt == DIV_LAST) begin
                        state        <= ST_DONE;
                        o_flash_cs_n <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    boot_done <= 1'b1;
`ifdef FLASH_BOOT_CHECKSUM_EN
                    core_rst_n <= !boot_err;
`else
                    core_rst_n <= 1'b1;
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_boot_loader.sv
// tb_flash_boot_loader: directed bench with a mode-0 SPI READ flash model.
// Define FLASH_BOOT_CHECKSUM_EN to also exercise the trailer checksum path.
`timescale 1ns/1ps
module tb_flash_boot_loader;
    localparam int D = 4;
`ifdef FLASH_BOOT_CHECKSUM_EN
    localparam int NW = D + 1;
`else
    localparam int NW = D;
`endif
    localparam int BITS  = 32 + 32 * NW;
    localparam int LAT_A = 2 * 1 * BITS + 2 * 1 + 2;
    localparam int LAT_B = 2 * 3 * BITS + 2 * 3 + 2;
    localparam int FB    = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, a_sclk, a_cs_n, a_mosi, a_miso, a_we, a_core, a_done;
    logic [1:0]  a_addr;
    logic [31:0] a_wdata;
    logic        rst_b, b_sclk, b_cs_n, b_mosi, b_miso, b_we, b_core, b_done;
    logic [1:0]  b_addr;
    logic [31:0] b_wdata;
`ifdef FLASH_BOOT_CHECKSUM_EN
    logic        a_err, b_err;
`endif
    logic        tog_en, tog;

    flash_boot_loader #(
        .IMEM_DEPTH(D), .FLASH_BASE_ADDR(24'h300000), .SCLK_DIV(1)
    ) dut_a (
        .clk(clk), .reset_n(rst_a),
        .o_flash_sclk(a_sclk), .o_flash_cs_n(a_cs_n),
        .o_flash_mosi(a_mosi), .i_flash_miso(a_miso),
        .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
        .core_rst_n(a_core), .boot_done(a_done)
`ifdef FLASH_BOOT_CHECKSUM_EN
        , .boot_err(a_err)
`endif
    );

    flash_boot_loader #(
        .IMEM_DEPTH(D), .FLASH_BASE_ADDR(24'h300000), .SCLK_DIV(3)
    ) dut_b (
        .clk(clk), .reset_n(rst_b),
        .o_flash_sclk(b_sclk), .o_flash_cs_n(b_cs_n),
        .o_flash_mosi(b_mosi), .i_flash_miso(b_miso),
        .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
        .core_rst_n(b_core), .boot_done(b_done)
`ifdef FLASH_BOOT_CHECKSUM_EN
        , .boot_err(b_err)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    logic [31:0] img_a [5];
    logic [31:0] img_b [5];
    logic [7:0]  a_flash [FB];
    logic [7:0]  b_flash [FB];

    function automatic logic flash_bit(input logic [7:0] mem [FB], input int j);
        logic [7:0] b;
        if (j / 8 >= FB) return 1'b0;
        b = mem[j / 8];
        return b[7 - (j % 8)];
    endfunction

    int          a_fbits = 0, b_fbits = 0;
    logic [31:0] a_fsr = '0, a_hdr = '0, b_fsr = '0, b_hdr = '0;
    logic        a_fmiso = 1'b0, b_fmiso = 1'b0;

    always @(posedge a_sclk or posedge a_cs_n) begin
        if (a_cs_n) a_fbits = 0;
        else begin
            a_fsr = {a_fsr[30:0], a_mosi};
            a_fbits++;
            if (a_fbits == 32) a_hdr = a_fsr;
        end
    end
    always @(negedge a_sclk or posedge a_cs_n) begin
        if (a_cs_n) a_fmiso = 1'b0;
        else if (a_fbits >= 32) a_fmiso = flash_bit(a_flash, a_fbits - 32);
    end

    always @(posedge b_sclk or posedge b_cs_n) begin
        if (b_cs_n) b_fbits = 0;
        else begin
            b_fsr = {b_fsr[30:0], b_mosi};
            b_fbits++;
            if (b_fbits == 32) b_hdr = b_fsr;
        end
    end
    always @(negedge b_sclk or posedge b_cs_n) begin
        if (b_cs_n) b_fmiso = 1'b0;
        else if (b_fbits >= 32) b_fmiso = flash_bit(b_flash, b_fbits - 32);
    end

    assign a_miso = tog_en ? tog : a_fmiso;
    assign b_miso = b_fmiso;

    int          a_wr_n = 0, a_edges = 0, a_cs_low = 0;
    logic [31:0] a_wr_addr [64];
    logic [31:0] a_wr_data [64];

    always @(negedge clk) begin
        if (a_we === 1'b1) begin
            if (a_wr_n < 64) begin
                a_wr_addr[a_wr_n] = 32'(a_addr);
                a_wr_data[a_wr_n] = a_wdata;
            end
            a_wr_n++;
        end
        if (a_cs_n !== 1'b1) a_cs_low++;
    end
    always @(posedge a_sclk or negedge a_sclk) a_edges++;

    logic        b_prev = 1'b0, b_got = 1'b0;
    int          b_run = 0, b_hi_bad = 0, b_lo_bad = 0, b_rises = 0;
    int          b_cs_cnt = 0, b_setup = 0, b_since = 0;
    logic [31:0] b_addr0 = '0, b_data0 = '0;

    always @(negedge clk) begin
        if (rst_b === 1'b1) begin
            if (b_sclk && !b_prev) begin
                if (b_rises == 0) b_setup = b_cs_cnt;
                else if (b_run != 3) b_lo_bad++;
                b_rises++;
                b_since = 0;
            end else if (!b_sclk && b_prev) begin
                if (b_run != 3) b_hi_bad++;
            end
            if (b_sclk != b_prev) b_run = 1;
            else b_run++;
            if (!b_cs_n) begin
                b_cs_cnt++;
                b_since++;
            end
            b_prev = b_sclk;
            if (b_we && !b_got) begin
                b_got   = 1'b1;
                b_addr0 = 32'(b_addr);
                b_data0 = b_wdata;
            end
        end
    end

    task automatic boot_a(output int n);
        n = 0;
        @(negedge clk);
        rst_a = 1'b1;
        while (a_done !== 1'b1 && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic reset_a();
        @(negedge clk);
        rst_a = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic load_flash();
        for (int i = 0; i < FB; i++) begin
            a_flash[i] = 8'h00;
            b_flash[i] = 8'h00;
        end
        for (int w = 0; w < NW; w++)
            for (int b = 0; b < 4; b++) begin
                a_flash[4 * w + b] = img_a[w][8 * b +: 8];
                b_flash[4 * w + b] = img_b[w][8 * b +: 8];
            end
    endtask

    int lat, base, waited, e0, w0, c0;

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; tog_en = 1'b0; tog = 1'b0;
        img_b[0] = 32'hDEADBEEF; img_b[1] = 32'h11223344;
        img_b[2] = 32'h00000013; img_b[3] = 32'hCAFEF00D;
        img_a[4] = '0; img_b[4] = '0;
        for (int i = 0; i < D; i++) begin
            img_a[i] = 32'h00000013;
            img_a[4] = img_a[4] + img_a[i];
            img_b[4] = img_b[4] + img_b[i];
        end
        load_flash();
        repeat (3) @(negedge clk);

        check("rst_sclk", 32'(a_sclk), 0);
        check("rst_cs_n", 32'(a_cs_n), 1);
        check("rst_mosi", 32'(a_mosi), 0);
        check("rst_we", 32'(a_we), 0);
        check("rst_addr", 32'(a_addr), 0);
        check("rst_wdata", a_wdata, 0);
        check("rst_core", 32'(a_core), 0);
        check("rst_done", 32'(a_done), 0);

        base = a_wr_n;
        boot_a(lat);
        check("t1_latency", lat, LAT_A);
        check("t1_header", a_hdr, 32'h03300000);
        check("t1_nwrites", a_wr_n - base, D);
        for (int i = 0; i < D; i++) begin
            check($sformatf("t1_addr%0d", i), a_wr_addr[base + i], i);
            check($sformatf("t1_data%0d", i), a_wr_data[base + i], 32'h13);
        end
        check("t1_addr_hold", 32'(a_addr), D - 1);
        check("t1_cs_n", 32'(a_cs_n), 1);
        check("t1_core", 32'(a_core), 1);
`ifdef FLASH_BOOT_CHECKSUM_EN
        check("t6_good_err", 32'(a_err), 0);
`endif

        reset_a();
        base = a_wr_n;
        @(negedge clk);
        rst_a = 1'b1;
        waited = 0;
        while (a_wr_n - base < 2 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check("t4_reach_word2", 32'(waited < 2000), 1);
        repeat (10) @(negedge clk);
        rst_a = 1'b0;
        #1;
        check("t4_abort_cs_n", 32'(a_cs_n), 1);
        check("t4_abort_core", 32'(a_core), 0);
        check("t4_abort_sclk", 32'(a_sclk), 0);
        repeat (2) @(negedge clk);
        base = a_wr_n;
        boot_a(lat);
        check("t4_latency", lat, LAT_A);
        check("t4_nwrites", a_wr_n - base, D);
        for (int i = 0; i < D; i++) begin
            check($sformatf("t4_addr%0d", i), a_wr_addr[base + i], i);
            check($sformatf("t4_data%0d", i), a_wr_data[base + i], img_a[i]);
        end

        e0 = a_edges; w0 = a_wr_n; c0 = a_cs_low;
        tog_en = 1'b1;
        repeat (1000) begin
            @(negedge clk);
            tog = ~tog;
        end
        tog_en = 1'b0;
        check("t5_sclk_edges", a_edges - e0, 0);
        check("t5_writes", a_wr_n - w0, 0);
        check("t5_cs_low", a_cs_low - c0, 0);
        check("t5_done", 32'(a_done), 1);

        @(negedge clk);
        rst_b = 1'b1;
        lat = 0;
        while (b_done !== 1'b1 && lat < 40000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("t3_latency", lat, LAT_B);
        check("t3_header", b_hdr, 32'h03300000);
        check("t3_rises", b_rises, BITS);
        check("t3_high_bad", b_hi_bad, 0);
        check("t3_low_bad", b_lo_bad, 0);
        check("t3_setup", 32'(b_setup >= 3), 1);
        check("t3_hold", 32'(b_since >= 3), 1);
        check("t2_addr0", b_addr0, 0);
        check("t2_data0", b_data0, 32'hDEADBEEF);
        check("t3_core", 32'(b_core), 1);

`ifdef FLASH_BOOT_CHECKSUM_EN
        reset_a();
        a_flash[4 * D] = a_flash[4 * D] ^ 8'h01;
        boot_a(lat);
        check("t6_bad_latency", lat, LAT_A);
        check("t6_bad_err", 32'(a_err), 1);
        check("t6_bad_core", 32'(a_core), 0);
        check("t6_bad_done", 32'(a_done), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
